psum_ofifo: RTL and testbench

//  Output-side collector for the MAC column array: the receiving end of each column's fifo_wr/out psum stream.

---
 rtl/psum_ofifo.sv | 85 ++++++++
 tb/tb_psum_ofifo.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_ofifo.sv
// Output-side psum collector: one ring-buffer lane per MAC column, written independently,
// read out as a whole row once every lane holds data.
module psum_ofifo #(
   parameter int col     = 8,
   parameter int bw_psum = 22,
   parameter int depth   = 16,
   parameter int aw      = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [col-1:0]           wr,
   input  logic [col*bw_psum-1:0]   in,
   input  logic                     rd,
   output logic [col*bw_psum-1:0]   out,
   output logic                     o_valid,
   output logic                     o_full,
   output logic                     o_ready,
   output logic                     o_ovf,
   output logic                     o_unf
);

   localparam logic [aw:0] ptr_one = {{aw{1'b0}}, 1'b1};

   // Rows always pop as a unit, so every lane's read pointer is identical: keep just one.
   logic [aw:0]    rptr;
   logic [col-1:0] lane_empty;
   logic [col-1:0] lane_full;
   logic [col-1:0] lane_acc;
   logic [col-1:0] lane_drop;
   logic           pop;
   logic           ovf_r;
   logic           unf_r;

   assign o_valid = ~|lane_empty;
   assign o_full  = |lane_full;
   assign o_ready = ~o_full;
   assign pop     = rd & o_valid;
   assign o_ovf   = ovf_r;
   assign o_unf   = unf_r;

   for (genvar i = 0; i < col; i++) begin : g_lane
      logic signed [bw_psum-1:0] mem [depth];
      logic [aw:0]               wptr;

      assign lane_empty[i] = (wptr == rptr);
      assign lane_full[i]  = (wptr[aw-1:0] == rptr[aw-1:0]) && (wptr[aw] != rptr[aw]);
      // A pop in the same cycle frees the head slot, which is exactly where a full lane writes.
      assign lane_acc[i]   = wr[i] & (~lane_full[i] | pop);
      assign lane_drop[i]  = wr[i] & lane_full[i] & ~pop;

      always_ff @(posedge clk) begin
         if (reset)
            wptr <= '0;
         else if (lane_acc[i])
            wptr <= wptr + ptr_one;
      end

      always_ff @(posedge clk) begin
         if (lane_acc[i])
            mem[wptr[aw-1:0]] <= in[i*bw_psum +: bw_psum];
      end

      assign out[i*bw_psum +: bw_psum] = mem[rptr[aw-1:0]];
   end

   always_ff @(posedge clk) begin
      if (reset)
         rptr <= '0;
      else if (pop)
         rptr <= rptr + ptr_one;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_r <= 1'b0;
         unf_r <= 1'b0;
      end else begin
         if (|lane_drop)
            ovf_r <= 1'b1;
         if (rd & ~o_valid)
            unf_r <= 1'b1;
      end
   end

endmodule

// File: tb/tb_psum_ofifo.sv
// Bench for psum_ofifo: queue-per-lane reference model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_psum_ofifo;

   localparam int COL   = 8;
   localparam int BW    = 22;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic                clk;
   logic                reset;
   logic [COL-1:0]      wr;
   logic [COL*BW-1:0]   in_d;
   logic                rd;
   logic [COL*BW-1:0]   out;
   logic                o_valid, o_full, o_ready, o_ovf, o_unf;

   psum_ofifo #(.col(COL), .bw_psum(BW), .depth(DEPTH), .aw(AW)) dut (
      .clk(clk), .reset(reset), .wr(wr), .in(in_d), .rd(rd), .out(out),
      .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready), .o_ovf(o_ovf), .o_unf(o_unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   bit run_cmp = 0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: a plain queue per lane plus the two sticky flags.
   logic [BW-1:0] q [COL][$];
   bit            m_ovf, m_unf;
   bit            m_all, m_pop;
   bit [COL-1:0]  m_acc;

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < COL; i++) q[i].delete();
         m_ovf = 0;
         m_unf = 0;
      end else begin
         m_all = 1;
         for (int i = 0; i < COL; i++) if (q[i].size() == 0) m_all = 0;
         m_pop = rd && m_all;
         if (rd && !m_all) m_unf = 1;
         m_acc = '0;
         for (int i = 0; i < COL; i++) begin
            if (wr[i]) begin
               if (q[i].size() < DEPTH || m_pop) m_acc[i] = 1;
               else m_ovf = 1;
            end
         end
         if (m_pop) for (int i = 0; i < COL; i++) void'(q[i].pop_front());
         for (int i = 0; i < COL; i++) if (m_acc[i]) q[i].push_back(in_d[i*BW +: BW]);
      end
   end

   always @(posedge clk) begin
      bit             e_valid, e_full;
      logic [COL*BW-1:0] e_out;
      #1;
      if (run_cmp) begin
         e_valid = 1;
         e_full  = 0;
         e_out   = '0;
         for (int i = 0; i < COL; i++) begin
            if (q[i].size() == 0) e_valid = 0;
            else e_out[i*BW +: BW] = q[i][0];
            if (q[i].size() == DEPTH) e_full = 1;
         end
         chk("cmp_valid", 256'(o_valid), 256'(e_valid));
         chk("cmp_full", 256'(o_full), 256'(e_full));
         chk("cmp_ready", 256'(o_ready), 256'(!e_full));
         chk("cmp_ovf", 256'(o_ovf), 256'(m_ovf));
         chk("cmp_unf", 256'(o_unf), 256'(m_unf));
         if (e_valid) chk("cmp_out", 256'(out), 256'(e_out));
      end
   end

   function automatic logic [COL*BW-1:0] pack_all(input int v);
      logic [COL*BW-1:0] r;
      for (int i = 0; i < COL; i++) r[i*BW +: BW] = BW'(v);
      return r;
   endfunction

   function automatic logic [COL*BW-1:0] pack_lanes(input int base);
      logic [COL*BW-1:0] r;
      for (int i = 0; i < COL; i++) r[i*BW +: BW] = BW'(base + i);
      return r;
   endfunction

   function automatic int stream_val(input int row, input int lane);
      if (row % 2 == 1) return -(row*8 + lane + 1);
      return 1000 + row*8 + lane;
   endfunction

   task automatic step(input logic [COL-1:0] w, input logic [COL*BW-1:0] d, input logic r);
      wr   = w;
      in_d = d;
      rd   = r;
      @(negedge clk);
      wr   = '0;
      rd   = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      wr    = '0;
      rd    = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   int cnt [COL];
   int mn, popped, cyc;
   logic [COL-1:0]    w_v;
   logic [COL*BW-1:0] d_v;
   bit                all_done;

   initial begin
      reset = 1'b1;
      wr    = '0;
      in_d  = '0;
      rd    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      run_cmp = 1;
      chk("rst_valid", 256'(o_valid), 256'(0));
      chk("rst_full", 256'(o_full), 256'(0));
      chk("rst_ready", 256'(o_ready), 256'(1));
      chk("rst_ovf", 256'(o_ovf), 256'(0));
      chk("rst_unf", 256'(o_unf), 256'(0));

      // Full row in one cycle
      step(8'hFF, pack_lanes(1), 1'b0);
      chk("t1_valid", 256'(o_valid), 256'(1));
      chk("t1_out", 256'(out), 256'(pack_lanes(1)));
      step('0, '0, 1'b1);
      chk("t1_pop", 256'(o_valid), 256'(0));

      // Skewed lane writes
      for (int i = 0; i < COL; i++) begin
         chk("t2_wait", 256'(o_valid), 256'(0));
         d_v = '0;
         d_v[i*BW +: BW] = BW'(100 + i);
         step(COL'(1) << i, d_v, 1'b0);
      end
      chk("t2_valid", 256'(o_valid), 256'(1));
      chk("t2_out", 256'(out), 256'(pack_lanes(100)));
      step('0, '0, 1'b1);

      // Overflow on lane 0
      for (int k = 0; k < DEPTH; k++) step(8'h01, pack_all(200 + k), 1'b0);
      chk("t3_full", 256'(o_full), 256'(1));
      chk("t3_ready", 256'(o_ready), 256'(0));
      chk("t3_noovf", 256'(o_ovf), 256'(0));
      step(8'h01, pack_all(999), 1'b0);
      chk("t3_ovf", 256'(o_ovf), 256'(1));
      step(8'hFE, pack_all(7), 1'b0);
      chk("t3_head", 256'(out[BW-1:0]), 256'(200));
      do_reset();

      // Write and pop together while every lane is full
      for (int k = 0; k < DEPTH; k++) step(8'hFF, pack_lanes(300 + k*16), 1'b0);
      chk("t4_full", 256'(o_full), 256'(1));
      step(8'hFF, pack_all(55), 1'b1);
      chk("t4_full_kept", 256'(o_full), 256'(1));
      chk("t4_noovf", 256'(o_ovf), 256'(0));
      chk("t4_head", 256'(out), 256'(pack_lanes(316)));
      for (int k = 0; k < DEPTH; k++) begin
         if (k == DEPTH-1) chk("t4_last", 256'(out), 256'(pack_all(55)));
         step('0, '0, 1'b1);
      end
      chk("t4_empty", 256'(o_valid), 256'(0));

      // Underflow with lane 7 missing
      step(8'h7F, pack_lanes(500), 1'b0);
      step('0, '0, 1'b1);
      chk("t5_unf", 256'(o_unf), 256'(1));
      chk("t5_novalid", 256'(o_valid), 256'(0));
      step(8'h80, pack_all(507), 1'b0);
      chk("t5_valid", 256'(o_valid), 256'(1));
      chk("t5_out", 256'(out), 256'(pack_lanes(500)));
      step('0, '0, 1'b1);
      chk("t5_popped", 256'(o_valid), 256'(0));

      // Long skewed stream across pointer wrap
      do_reset();
      for (int i = 0; i < COL; i++) cnt[i] = 0;
      popped = 0;
      cyc = 0;
      all_done = 0;
      while (!all_done && cyc < 2000) begin
         mn = cnt[0];
         for (int i = 1; i < COL; i++) if (cnt[i] < mn) mn = cnt[i];
         w_v = '0;
         d_v = '0;
         for (int i = 0; i < COL; i++) begin
            if (cnt[i] < 40 && cnt[i] - mn < 3 && $urandom_range(0, 1) == 1) begin
               w_v[i] = 1'b1;
               d_v[i*BW +: BW] = BW'(stream_val(cnt[i], i));
               cnt[i]++;
            end
         end
         if (o_valid) popped++;
         step(w_v, d_v, o_valid);
         cyc++;
         all_done = 1;
         for (int i = 0; i < COL; i++) if (cnt[i] < 40) all_done = 0;
      end
      while (o_valid && cyc < 2200) begin
         popped++;
         step('0, '0, 1'b1);
         cyc++;
      end
      chk("t6_in_time", 256'(cyc < 2200), 256'(1));
      chk("t6_rows", 256'(popped), 256'(40));
      chk("t6_ovf", 256'(o_ovf), 256'(0));
      chk("t6_unf", 256'(o_unf), 256'(0));

      // Reset mid-stream clears data and stickies
      step(8'hFF, pack_lanes(2000), 1'b0);
      step(8'h0F, pack_lanes(3000), 1'b1);
      step('0, '0, 1'b1);
      chk("t6_unf_set", 256'(o_unf), 256'(1));
      step(8'hFF, pack_lanes(4000), 1'b0);
      reset = 1'b1;
      wr    = 8'hFF;
      in_d  = pack_lanes(5000);
      rd    = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      wr    = '0;
      rd    = 1'b0;
      chk("t6_rst_valid", 256'(o_valid), 256'(0));
      chk("t6_rst_ovf", 256'(o_ovf), 256'(0));
      chk("t6_rst_unf", 256'(o_unf), 256'(0));
      chk("t6_rst_ready", 256'(o_ready), 256'(1));
      step('0, '0, 1'b0);
      chk("t6_rst_idle", 256'(o_valid), 256'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
